// File: rtl/jbus_arbiter_pkg.sv
// Shared definitions for the jbus round-robin arbiter.
// State encodings and transfer phase lengths.
package jbus_arbiter_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EN   = 2'd1;
    localparam logic [1:0] S_SET  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam int EN_CYCLES   = 1;
    localparam int SET_CYCLES  = 1;
    localparam int HOLD_CYCLES = 1;
    localparam int XFER_CYCLES = EN_CYCLES + SET_CYCLES + HOLD_CYCLES;

endpackage

// File: rtl/jbus_arbiter_pick.sv
// Round-robin winner search and index-to-one-hot decoder
// used by the jbus arbiter.
module jrr_pick
    import jbus_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int NW = 2
) (
    input  logic [N-1:0]  breq_masked,
    input  logic [NW-1:0] ptr,
    output logic          found,
    output logic [NW-1:0] idx
);

    logic [NW-1:0] cand;

    // Walk N slots starting just after ptr, wrapping at N (not 2**NW).
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = ptr;
        for (int i = 0; i < N; i++) begin
            cand = (cand == NW'(N - 1)) ? '0 : cand + NW'(1);
            if (!found && breq_masked[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

module jdecoder #(
    parameter int W = 2,
    parameter int M = 4
) (
    input  logic [W-1:0] sel,
    output logic [M-1:0] dec
);

    always_comb begin
        dec = '0;
        for (int i = 0; i < M; i++) begin
            dec[i] = (sel == W'(i));
        end
    end

endmodule

// File: rtl/jbus_arbiter.sv
// Round-robin owner scheduler for the shared 8-bit bus:
// sequences enable/set/hold for each granted transfer.
module jbus_arbiter
    import jbus_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int NW = 2
) (
    input  logic         wclk,
    input  logic         wreset_n,
    input  logic [N-1:0] breq,
    input  logic [N-1:0] bbus1,
    output logic [N-1:0] bgnt,
    output logic         wenable,
    output logic         wset,
    output logic         wbus1,
    output logic [N-1:0] back,
    output logic         wbusy
);

    logic [1:0]    state;
    logic [NW-1:0] ptr;
    logic [NW-1:0] gidx;
    logic [NW-1:0] pick;
    logic          found;
    logic          busy;
    logic [N-1:0]  onehot;
    logic [N-1:0]  masked;

    assign busy    = (state != S_IDLE);
    assign bgnt    = onehot & {N{busy}};
    assign masked  = breq & ~bgnt;
    assign wenable = busy;
    assign wset    = (state == S_SET);
    assign back    = (state == S_HOLD) ? bgnt : '0;
    assign wbusy   = busy;

    jrr_pick #(
        .N  (N),
        .NW (NW)
    ) u_pick (
        .breq_masked (masked),
        .ptr         (ptr),
        .found       (found),
        .idx         (pick)
    );

    // Only indices below N are ever latched, so N outputs suffice.
    jdecoder #(
        .W (NW),
        .M (N)
    ) u_dec (
        .sel (gidx),
        .dec (onehot)
    );

    always_ff @(posedge wclk or negedge wreset_n) begin
        if (!wreset_n) begin
            state <= S_IDLE;
            ptr   <= NW'(N - 1);
            gidx  <= '0;
            wbus1 <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_HOLD: begin
                    if (found) begin
                        state <= S_EN;
                        gidx  <= pick;
                        ptr   <= pick;
                        wbus1 <= bbus1[pick];
                    end else begin
                        state <= S_IDLE;
                        wbus1 <= 1'b0;
                    end
                end
                S_EN:  state <= S_SET;
                S_SET: state <= S_HOLD;
            endcase
        end
    end

endmodule
